// File: rtl/lock_pkg.sv
// Shared state type and key constants for the keypad lock controller.
// The LOCKOUT state only exists when LOCK_CTRL_LOCKOUT_EN is defined.
package lock_pkg;

    localparam int         DIGIT_W       = 4;
    localparam logic [4:0] KEY_CLEAR     = 5'd15;
    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;

    typedef enum logic [2:0] {
        LOCKED,
        ENTER,
        CHECK,
        OPEN,
`ifdef LOCK_CTRL_LOCKOUT_EN
        LOCKOUT,
`endif
        SET
    } lock_state_t;

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: load starts a run of CYCLES cycles, expire_o marks the last one.
// Only instantiated when LOCK_CTRL_LOCKOUT_EN is defined.
module lockout_timer #(
    parameter int CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expire_o
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count_q, count_d;
    logic         running_q, running_d;

    // Loading CYCLES-1 makes expire_o land on the CYCLES-th cycle after the load.
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        if (load_i) begin
            count_d   = W'(CYCLES - 1);
            running_d = 1'b1;
        end else if (running_q) begin
            if (count_q == '0) begin
                running_d = 1'b0;
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    assign expire_o = running_q && (count_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: code entry, compare, password change, re-lock and lockout.
// Define LOCK_CTRL_LOCKOUT_EN to enable the lockout state, timer and alarm.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                  DIGITS         = 6,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 50_000_000,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = '0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_flag,
    input  logic [4:0] key_value,
    input  logic       btn0,
    input  logic       btn3,
    output logic       open,
    output logic       alarm,
    output logic [1:0] fail_cnt,
    output logic [3:0] digit_cnt,
    output logic       match
);

    localparam int         CODE_W   = DIGIT_W * DIGITS;
    localparam logic [3:0] LAST_CNT = 4'(DIGITS - 1);
    localparam logic [1:0] FAIL_SAT = 2'(MAX_FAIL);

    lock_state_t       state_q, state_d;
    logic [CODE_W-1:0] buf_q, buf_d, code_q, code_d, bufShift;
    logic [3:0]        dcnt_q, dcnt_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic              open_q, open_d, match_q, match_d;
    logic              btn0_q, btn3_q;
    logic              btn0Edge, btn3Edge, isDigit, isClear, lastDigit, codeEq;

`ifdef LOCK_CTRL_LOCKOUT_EN
    logic tmrLoad, tmrExpire, alarm_q, alarm_d;

    lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmrLoad),
        .expire_o(tmrExpire)
    );
`else
    logic unused_lockout_cfg;
    assign unused_lockout_cfg = (LOCKOUT_CYCLES > 0);
`endif

    // Button edges take priority over keys; a key in the same cycle as an accepted edge is dropped.
    always_comb begin
        btn0Edge  = btn0 & ~btn0_q;
        btn3Edge  = btn3 & ~btn3_q;
        isDigit   = key_flag && (key_value <= KEY_DIGIT_MAX);
        isClear   = key_flag && (key_value == KEY_CLEAR);
        lastDigit = (dcnt_q == LAST_CNT);
        codeEq    = (buf_q == code_q);
        bufShift  = {buf_q[CODE_W-DIGIT_W-1:0], key_value[DIGIT_W-1:0]};
        state_d   = state_q;
        buf_d     = buf_q;
        code_d    = code_q;
        dcnt_d    = dcnt_q;
        fcnt_d    = fcnt_q;
        match_d   = 1'b0;
`ifdef LOCK_CTRL_LOCKOUT_EN
        tmrLoad   = 1'b0;
`endif
        case (state_q)
            LOCKED, ENTER: begin
                if (btn0Edge || isClear) begin
                    state_d = LOCKED;
                    buf_d   = '0;
                    dcnt_d  = '0;
                end else if (isDigit) begin
                    buf_d   = bufShift;
                    dcnt_d  = dcnt_q + 4'd1;
                    state_d = lastDigit ? CHECK : ENTER;
                end
            end
            CHECK: begin
                buf_d  = '0;
                dcnt_d = '0;
                if (codeEq) begin
                    state_d = OPEN;
                    fcnt_d  = '0;
                    match_d = 1'b1;
                end else begin
                    fcnt_d  = (fcnt_q == FAIL_SAT) ? FAIL_SAT : fcnt_q + 2'd1;
                    state_d = LOCKED;
`ifdef LOCK_CTRL_LOCKOUT_EN
                    if (fcnt_d == FAIL_SAT) begin
                        state_d = LOCKOUT;
                        tmrLoad = 1'b1;
                    end
`endif
                end
            end
            OPEN: begin
                if (btn0Edge) begin
                    state_d = LOCKED;
                end else if (btn3Edge) begin
                    state_d = SET;
                    buf_d   = '0;
                    dcnt_d  = '0;
                end
            end
            SET: begin
                if (btn0Edge) begin
                    state_d = LOCKED;
                    buf_d   = '0;
                    dcnt_d  = '0;
                end else if (isClear) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                end else if (isDigit) begin
                    if (lastDigit) begin
                        code_d  = bufShift;
                        state_d = OPEN;
                        buf_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        buf_d  = bufShift;
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end
            end
`ifdef LOCK_CTRL_LOCKOUT_EN
            LOCKOUT: begin
                if (tmrExpire) begin
                    state_d = LOCKED;
                    fcnt_d  = '0;
                end
            end
`endif
            default: state_d = LOCKED;
        endcase
        open_d = (state_d == OPEN) || (state_d == SET);
`ifdef LOCK_CTRL_LOCKOUT_EN
        alarm_d = (state_d == LOCKOUT);
`endif
    end

    // Button history resets high so a level held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOCKED;
            buf_q   <= '0;
            code_q  <= DEFAULT_CODE;
            dcnt_q  <= '0;
            fcnt_q  <= '0;
            open_q  <= 1'b0;
            match_q <= 1'b0;
            btn0_q  <= 1'b1;
            btn3_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            dcnt_q  <= dcnt_d;
            fcnt_q  <= fcnt_d;
            open_q  <= open_d;
            match_q <= match_d;
            btn0_q  <= btn0;
            btn3_q  <= btn3;
        end
    end

`ifdef LOCK_CTRL_LOCKOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    assign open      = open_q;
    assign match     = match_q;
    assign fail_cnt  = fcnt_q;
    assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: directed scenarios plus random key/button traffic,
// compared every cycle against a digit-queue model of the lock (honours LOCK_CTRL_LOCKOUT_EN).
module tb_lock_ctrl;

    localparam int DIGITS   = 6;
    localparam int MAX_FAIL = 3;
    localparam int LC       = 100;
`ifdef LOCK_CTRL_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       key_flag;
    logic [4:0] key_value;
    logic       btn0;
    logic       btn3;
    logic       open;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [3:0] digit_cnt;
    logic       match;

    lock_ctrl #(
        .DIGITS        (DIGITS),
        .MAX_FAIL      (MAX_FAIL),
        .LOCKOUT_CYCLES(LC),
        .DEFAULT_CODE  (24'h000000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_flag (key_flag),
        .key_value(key_value),
        .btn0     (btn0),
        .btn3     (btn3),
        .open     (open),
        .alarm    (alarm),
        .fail_cnt (fail_cnt),
        .digit_cnt(digit_cnt),
        .match    (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the lock as a digit queue, a stored digit array and a few mode flags.
    int mEntry[$];
    int mCode[DIGITS];
    bit mUnlocked, mSetting, mPending, mMatch, mB0Prev, mB3Prev;
    int mLockLeft, mFails;

    int compared   = 0;
    int mismatched = 0;

    function automatic void modelReset();
        mEntry.delete();
        for (int i = 0; i < DIGITS; i++) mCode[i] = 0;
        mUnlocked = 1'b0;
        mSetting  = 1'b0;
        mPending  = 1'b0;
        mMatch    = 1'b0;
        mB0Prev   = 1'b1;
        mB3Prev   = 1'b1;
        mLockLeft = 0;
        mFails    = 0;
    endfunction

    function automatic void modelStep(input bit flag, input int val, input bit b0, input bit b3);
        bit e0, e3, digit, clr, same;
        e0      = b0 && !mB0Prev;
        e3      = b3 && !mB3Prev;
        mB0Prev = b0;
        mB3Prev = b3;
        digit   = flag && (val <= 9);
        clr     = flag && (val == 15);
        mMatch  = 1'b0;
        if (mLockLeft > 0) begin
            mLockLeft--;
            if (mLockLeft == 0) mFails = 0;
        end else if (mPending) begin
            mPending = 1'b0;
            same = 1'b1;
            for (int i = 0; i < DIGITS; i++) if (mEntry[i] != mCode[i]) same = 1'b0;
            mEntry.delete();
            if (same) begin
                mUnlocked = 1'b1;
                mFails    = 0;
                mMatch    = 1'b1;
            end else begin
                if (mFails < MAX_FAIL) mFails++;
                if (LOCKOUT_EN && mFails == MAX_FAIL) mLockLeft = LC;
            end
        end else if (mSetting) begin
            if (e0) begin
                mSetting  = 1'b0;
                mUnlocked = 1'b0;
                mEntry.delete();
            end else if (clr) begin
                mEntry.delete();
            end else if (digit) begin
                mEntry.push_back(val);
                if (mEntry.size() == DIGITS) begin
                    for (int i = 0; i < DIGITS; i++) mCode[i] = mEntry[i];
                    mEntry.delete();
                    mSetting = 1'b0;
                end
            end
        end else if (mUnlocked) begin
            if (e0) begin
                mUnlocked = 1'b0;
            end else if (e3) begin
                mSetting = 1'b1;
                mEntry.delete();
            end
        end else begin
            if (e0 || clr) begin
                mEntry.delete();
            end else if (digit) begin
                mEntry.push_back(val);
                if (mEntry.size() == DIGITS) mPending = 1'b1;
            end
        end
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("open",      32'(open),      32'(mUnlocked));
        checkOne("alarm",     32'(alarm),     32'(mLockLeft > 0));
        checkOne("fail_cnt",  32'(fail_cnt),  32'(mFails));
        checkOne("digit_cnt", 32'(digit_cnt), 32'(mEntry.size()));
        checkOne("match",     32'(match),     32'(mMatch));
    endtask

    // Drives one cycle of inputs, advances the model at the edge, checks 1 time unit later.
    task automatic applyStimulus(input bit flag, input int val, input bit b0, input bit b3);
        key_flag  = flag;
        key_value = 5'(val);
        btn0      = b0;
        btn3      = b3;
        @(posedge clk);
        modelStep(flag, val, b0, b3);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
    task automatic pulseReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        #2;
        reset = 1'b0;
    endtask

    task automatic pressKey(input int v);
        applyStimulus(1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic pressBtn0();
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic pressBtn3();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] lock_ctrl bench start, lockout enabled = %0d", LOCKOUT_EN);
        reset     = 1'b0;
        key_flag  = 1'b0;
        key_value = '0;
        btn0      = 1'b0;
        btn3      = 1'b0;
        modelReset();
        #1;
        reset = 1'b1;
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();

        // Default code opens; open/match two cycles after the last strobe.
        repeat (6) pressKey(0);
        idle(3);

        // Change password to 123456, re-lock, reopen with it, then fail with the old code.
        pressBtn3();
        for (int i = 1; i <= 6; i++) pressKey(i);
        idle(1);
        pressBtn0();
        idle(1);
        for (int i = 1; i <= 6; i++) pressKey(i);
        idle(3);
        pressBtn0();
        idle(1);
        repeat (6) pressKey(0);
        idle(3);

        // Clear key part way through an entry.
        pulseReset();
        pressKey(1);
        pressKey(2);
        pressKey(3);
        pressKey(15);
        repeat (6) pressKey(0);
        idle(3);

        // Three wrong entries, then traffic that must be ignored during lockout.
        pulseReset();
        repeat (3) begin
            repeat (6) pressKey(9);
            idle(2);
        end
        for (int i = 0; i < LC + 10; i++)
            applyStimulus(1'b1, int'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(1);
        pressBtn0();
        idle(1);
        repeat (6) pressKey(9);
        idle(3);

        // btn0 edge with a key in the same cycle in SET aborts and drops the key.
        pulseReset();
        repeat (6) pressKey(0);
        idle(2);
        pressBtn3();
        pressKey(7);
        pressKey(7);
        applyStimulus(1'b1, 7, 1'b1, 1'b0);
        idle(1);
        repeat (6) pressKey(0);
        idle(2);

        // Reset after the 4th digit in SET restores the default code.
        pressBtn3();
        for (int i = 1; i <= 6; i++) pressKey(i);
        idle(1);
        pressBtn3();
        repeat (4) pressKey(5);
        pulseReset();
        repeat (6) pressKey(0);
        idle(2);

        // Random traffic biased toward the digit 0 so that matches also occur.
        pulseReset();
        for (int n = 0; n < 800; n++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 9));
            v = (r < 6) ? 0 : (r < 8) ? 1 : int'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), v,
                              ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Password-checking controller for the keypad lock. It consumes the stream of accepted key presses from the keyboard scanner, collects a fixed-length code, and compares it against the stored password. It drives `open` to the display/entry logic and handles password change, manual re-lock and lockout after repeated failures.

## Interface
- `DIGITS`, 6: code length in 4-bit digits.
- `MAX_FAIL`, 3: number of consecutive mismatches that triggers lockout.
- `LOCKOUT_CYCLES`, 50_000_000: lockout duration in `clk` cycles.
- `DEFAULT_CODE`, 24'h000000: stored password after reset, `4*DIGITS` bits, MSB digit first.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `key_flag`  in  1  one-`clk` strobe: `key_value` valid this cycle.
- `key_value`  in  5  key code. 0–9 are digits, 15 is clear, all others are ignored.
- `btn0`  in  1  lock request, level, already synchronised to `clk`.
- `btn3`  in  1  change-password request, level, already synchronised.
- `open`  out  1  high while unlocked (states OPEN, SET).
- `alarm`  out  1  high during lockout.
- `fail_cnt`  out  2  consecutive mismatches, saturating at `MAX_FAIL`.
- `digit_cnt`  out  4  digits collected in the current entry.
- `match`  out  1  one-cycle pulse on a successful compare.

## Operation
- States: LOCKED, ENTER, CHECK, OPEN, SET, LOCKOUT.
- Reset values:
  - state = LOCKED; stored code = `DEFAULT_CODE`; entry buffer = 0.
  - All outputs = 0.
  - Lockout timer = 0.
- Digit acceptance (ENTER, SET, and LOCKED):
  - A digit shifts into the entry buffer from the LSB end; the first key ends up in the MSB digit.
  - `digit_cnt` increments.
  - In LOCKED, the first digit moves the state to ENTER.
- Clear key (15) in ENTER/SET: buffer = 0 and `digit_cnt` = 0; state unchanged. In ENTER, clear returns to LOCKED.
- Entry complete: when the `DIGITS`-th digit is accepted, ENTER → CHECK.
- CHECK lasts exactly one cycle.
  - Match: → OPEN, `fail_cnt` = 0, `match` pulses.
  - Mismatch: `fail_cnt` + 1; → LOCKOUT if the new count equals `MAX_FAIL`, else → LOCKED.
  - Either way, buffer and `digit_cnt` are cleared.
- OPEN:
  - Rising edge of `btn0` → LOCKED.
  - Rising edge of `btn3` → SET, with buffer cleared.
  - Keys are ignored.
- SET:
  - The `DIGITS`-th digit writes buffer → stored code, then → OPEN.
  - `btn0` rising edge aborts to LOCKED; stored code unchanged.
- LOCKOUT:
  - `alarm` = 1; keys and buttons are ignored.
  - After `LOCKOUT_CYCLES` cycles → LOCKED, with `alarm` = 0 and `fail_cnt` = 0.
- Buttons are edge-detected internally. A level held through reset does not produce an edge on the first cycle after reset.
- Priority within one cycle: `btn0` edge > `btn3` edge > `key_flag`. A key coinciding with an accepted button edge is dropped.
- `btn0` in LOCKED/ENTER clears any partial entry. `btn3` outside OPEN is ignored.
- `key_flag` arriving during CHECK is dropped.

## Timing
- All outputs are registered.
- Last digit strobe at cycle N → state CHECK at N+1 → `open`/`match` (or updated `fail_cnt`/`alarm`) visible at N+2.
- `btn0` edge seen at cycle N (input high at N, low at N-1) → `open` low at N+1.
- In SET, last digit at N → stored code updated and state OPEN at N+1.
- Lockout timer:
  - Loaded at entry to LOCKOUT.
  - Counts down once per cycle.
  - Leaves at the cycle it reaches 0, giving exactly `LOCKOUT_CYCLES` cycles of `alarm` high.
- Reset mid-entry, mid-SET or mid-lockout: the asynchronous clear restores all reset values, including stored code = `DEFAULT_CODE`.
- Back-to-back `key_flag` strobes on consecutive cycles must all be accepted in LOCKED/ENTER/SET.

## Configuration
- `LOCK_CTRL_LOCKOUT_EN` defined:
  - LOCKOUT state, timer and `alarm` exist as described above.
- `LOCK_CTRL_LOCKOUT_EN` undefined:
  - No LOCKOUT state or timer.
  - `alarm` is tied 0.
  - A mismatch always goes to LOCKED.
  - `fail_cnt` still counts and saturates at `MAX_FAIL`.
  - `LOCKOUT_CYCLES` is unused.

## Structure
- Package `lock_pkg`:
  - State enum `lock_state_t`.
  - Key constants `KEY_CLEAR = 5'd15` and `KEY_DIGIT_MAX = 5'd9`.
  - Digit width constant 4.
- Sub-module `lockout_timer`: down-counter with a load strobe, an expire pulse and asynchronous reset. It is instantiated only under `LOCK_CTRL_LOCKOUT_EN`.
- Button edge detection and the compare stay in `lock_ctrl`.

## Test plan
- Reset, keys 0,0,0,0,0,0 → `open` = 1 and `match` pulse 2 cycles after the last strobe, `fail_cnt` = 0.
- Open, `btn3` edge, keys 1,2,3,4,5,6, `btn0` edge, keys 1,2,3,4,5,6 → `open` rises again. Same flow with keys 0×6 → `fail_cnt` = 1, `open` = 0.
- Three wrong entries of 9×6 with `LOCKOUT_CYCLES` = 100 → `alarm` high for exactly 100 cycles, keys ignored, then `fail_cnt` = 0. Without the macro: `alarm` stays 0 and `fail_cnt` saturates at 3.
- Keys 1,2,3, then 15, then 0×6 → clear empties the buffer and the entry opens; `digit_cnt` reads 3, 0, …, 6.
- `btn0` edge and `key_flag` in the same cycle in SET → abort to LOCKED, stored code unchanged, key dropped.
- Reset asserted after the 4th digit in SET → all outputs 0, stored code back to `DEFAULT_CODE`.
